// File: rtl/caravel_lite.sv
`default_nettype none
// ============================================================================
// Module   : caravel_lite
// Brief    : Streams a 3-byte record script from SPI flash and executes it
//            (checkbits, UART TX, delay, halt). Option: CARAVEL_LITE_WATCHDOG_EN
// Revision : 1.0
// ============================================================================
module caravel_lite #(
    parameter logic [23:0] START_ADDR  = 24'h000000,
    parameter int unsigned CLKDIV      = 4,
    parameter int unsigned WDOG_CYCLES = 300000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_io0,
    input  logic        flash_io1,
    output logic [37:0] mprj_io,
    output logic        gpio
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CMD       = 3'd1,
        S_FETCH     = 3'd2,
        S_EXEC      = 3'd3,
        S_UART_WAIT = 3'd4,
        S_DELAY     = 3'd5,
        S_HALT      = 3'd6
    } state_t;

    localparam logic [15:0] c_bit_last = 16'(CLKDIV - 1);

    state_t      state_q;
    logic        csb_q;
    logic        sclk_q;
    logic [31:0] sh_q;
    logic [23:0] rec_q;
    logic [4:0]  bitcnt_q;
    logic [15:0] chk_q;
    logic        tx_q;
    logic        done_q;
    logic [15:0] ucnt_q;
    logic [3:0]  ubit_q;
    logic [8:0]  ushift_q;
    logic [15:0] dcnt_q;
`ifdef CARAVEL_LITE_WATCHDOG_EN
    logic [31:0] wdog_q;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            csb_q    <= 1'b1;
            sclk_q   <= 1'b0;
            sh_q     <= '0;
            rec_q    <= '0;
            bitcnt_q <= '0;
            chk_q    <= '0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
            ucnt_q   <= '0;
            ubit_q   <= '0;
            ushift_q <= '0;
            dcnt_q   <= '0;
`ifdef CARAVEL_LITE_WATCHDOG_EN
            wdog_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    csb_q    <= 1'b0;
                    sclk_q   <= 1'b0;
                    sh_q     <= {8'h03, START_ADDR};
                    bitcnt_q <= '0;
                    state_q  <= S_CMD;
                end
                // Each SPI bit: one low cycle, one high cycle; MOSI shifts as clk falls.
                S_CMD: begin
                    if (!sclk_q) begin
                        sclk_q <= 1'b1;
                    end else begin
                        sclk_q   <= 1'b0;
                        sh_q     <= {sh_q[30:0], 1'b0};
                        bitcnt_q <= bitcnt_q + 5'd1;
                        if (bitcnt_q == 5'd31) begin
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (!sclk_q) begin
                        sclk_q <= 1'b1;
                    end else begin
                        sclk_q <= 1'b0;
                        rec_q  <= {rec_q[22:0], flash_io1};
                        if (bitcnt_q == 5'd23) begin
                            bitcnt_q <= '0;
                            state_q  <= S_EXEC;
                        end else begin
                            bitcnt_q <= bitcnt_q + 5'd1;
                        end
                    end
                end
                S_EXEC: begin
                    case (rec_q[23:16])
                        8'h01: begin
                            chk_q   <= rec_q[15:0];
                            state_q <= S_FETCH;
                        end
                        8'h02: begin
                            tx_q     <= 1'b0;
                            ucnt_q   <= c_bit_last;
                            ubit_q   <= '0;
                            ushift_q <= {1'b1, rec_q[7:0]};
                            state_q  <= S_UART_WAIT;
                        end
                        8'h03: begin
                            dcnt_q  <= rec_q[15:0];
                            state_q <= S_DELAY;
                        end
                        default: begin
                            csb_q   <= 1'b1;
                            sclk_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_HALT;
                        end
                    endcase
                end
                // ushift_q holds data bits then the stop bit; ubit_q==9 means stop bit has ended.
                S_UART_WAIT: begin
                    if (ucnt_q != '0) begin
                        ucnt_q <= ucnt_q - 16'd1;
                    end else if (ubit_q == 4'd9) begin
                        state_q <= S_FETCH;
                    end else begin
                        tx_q     <= ushift_q[0];
                        ushift_q <= {1'b0, ushift_q[8:1]};
                        ubit_q   <= ubit_q + 4'd1;
                        ucnt_q   <= c_bit_last;
                    end
                end
                S_DELAY: begin
                    if (dcnt_q == '0) begin
                        state_q <= S_FETCH;
                    end else begin
                        dcnt_q <= dcnt_q - 16'd1;
                    end
                end
                S_HALT: begin
                    csb_q  <= 1'b1;
                    sclk_q <= 1'b0;
                    done_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
`ifdef CARAVEL_LITE_WATCHDOG_EN
            // Watchdog overrides whatever the sequencer chose this cycle.
            if (state_q != S_HALT) begin
                if (wdog_q == 32'(WDOG_CYCLES - 1)) begin
                    chk_q   <= 16'hDEAD;
                    csb_q   <= 1'b1;
                    sclk_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_HALT;
                end else begin
                    wdog_q <= wdog_q + 32'd1;
                end
            end
`endif
        end
    end

    assign flash_csb = csb_q;
    assign flash_clk = sclk_q;
    assign flash_io0 = sh_q[31];
    assign gpio      = done_q;
    assign mprj_io   = {6'b0, chk_q, 9'b0, tx_q, 2'b0, 1'b1, 3'b0};

endmodule
`default_nettype wire

// File: tb/tb_caravel_lite.sv
`default_nettype none
// ============================================================================
// Module   : tb_caravel_lite
// Brief    : Directed table, random scripts and reset/watchdog sequences for
//            caravel_lite against an SPI flash model and a script-level model.
// Revision : 1.0
// ============================================================================
module tb_caravel_lite;

    localparam int CLKDIV = 4;
`ifdef CARAVEL_LITE_WATCHDOG_EN
    localparam int WDOG = 1000;
`else
    localparam int WDOG = 300000;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flash_csb;
    logic        flash_clk;
    logic        flash_io0;
    logic        flash_io1 = 1'b0;
    logic [37:0] mprj_io;
    logic        gpio;

    caravel_lite #(
        .START_ADDR (24'h000000),
        .CLKDIV     (CLKDIV),
        .WDOG_CYCLES(WDOG)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .flash_csb(flash_csb),
        .flash_clk(flash_clk),
        .flash_io0(flash_io0),
        .flash_io1(flash_io1),
        .mprj_io  (mprj_io),
        .gpio     (gpio)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // SPI flash: captures the command, then serves bytes from mem with auto-increment.
    logic [7:0]  mem [0:255];
    int unsigned rise_n;
    int unsigned fk;
    logic [23:0] fa;
    logic [7:0]  fbyte;
    logic [31:0] cmd_cap;
    always @(negedge flash_csb) begin
        rise_n  = 0;
        cmd_cap = '0;
    end
    always @(posedge flash_clk) begin
        if (rise_n < 32) begin
            cmd_cap = {cmd_cap[30:0], flash_io0};
        end else begin
            fk        = rise_n - 32;
            fa        = cmd_cap[23:0] + 24'(fk / 8);
            fbyte     = mem[fa[7:0]];
            flash_io1 = fbyte[7 - (fk % 8)];
        end
        rise_n++;
    end

    // Low-phase run length before every rising flash_clk, and checkbit changes.
    int unsigned lowrun;
    int unsigned gap_q[$];
    logic [15:0] chk_seen[$];
    logic [15:0] prev_chk;
    always @(negedge clock) begin
        if (reset) begin
            prev_chk = 16'h0;
            lowrun   = 0;
        end else begin
            if (mprj_io[31:16] !== prev_chk) begin
                chk_seen.push_back(mprj_io[31:16]);
                prev_chk = mprj_io[31:16];
            end
            if (flash_csb) lowrun = 0;
            else if (!flash_clk) lowrun++;
            else if (lowrun != 0) begin
                gap_q.push_back(lowrun);
                lowrun = 0;
            end
        end
    end

    // UART frame capture: {gpio at stop end, well-formed, byte}
    logic [9:0] uart_seen[$];
    logic [9:0] ub;
    logic       uok;
    logic       uabort;
    initial begin
        forever begin
            @(negedge clock);
            if (!reset && mprj_io[6] == 1'b0) begin
                uok    = 1'b1;
                uabort = 1'b0;
                for (int j = 0; j < 10 * CLKDIV; j++) begin
                    if (j > 0) @(negedge clock);
                    if (reset) begin
                        uabort = 1'b1;
                        break;
                    end
                    if (j % CLKDIV == 0) ub[j / CLKDIV] = mprj_io[6];
                    else if (mprj_io[6] !== ub[j / CLKDIV]) uok = 1'b0;
                end
                if (!uabort) begin
                    if (ub[0] !== 1'b0 || ub[9] !== 1'b1) uok = 1'b0;
                    uart_seen.push_back({gpio, uok, ub[8:1]});
                end
            end
        end
    end

    // Script-level reference: walks the records and predicts observable effects.
    logic [15:0] exp_chk[$];
    logic [9:0]  exp_uart[$];
    int unsigned exp_gap[$];
    logic [15:0] exp_final;
    function automatic void build_model(input logic [7:0] s[$]);
        logic [15:0] cur;
        logic [15:0] d;
        logic [7:0]  op;
        int unsigned carry;
        exp_chk.delete();
        exp_uart.delete();
        exp_gap.delete();
        cur   = '0;
        carry = 1;
        for (int i = 0; i < 32; i++) exp_gap.push_back(1);
        for (int r = 0; 3 * r + 2 < s.size(); r++) begin
            op = s[3*r];
            d  = {s[3*r+1], s[3*r+2]};
            exp_gap.push_back(carry);
            for (int i = 0; i < 23; i++) exp_gap.push_back(1);
            // record turnaround: one decode cycle plus the low phase of the next fetch bit
            carry = 2;
            if (op == 8'h01) begin
                if (d != cur) exp_chk.push_back(d);
                cur = d;
            end else if (op == 8'h02) begin
                exp_uart.push_back({1'b0, 1'b1, d[7:0]});
                carry += 10 * CLKDIV;
            end else if (op == 8'h03) begin
                carry += 32'(d) + 1;
            end else begin
                break;
            end
        end
        exp_final = cur;
    endfunction

    task automatic load_mem(input logic [7:0] s[$]);
        for (int i = 0; i < 256; i++) mem[i] = (i < s.size()) ? s[i] : 8'h00;
    endtask

    task automatic run_script(input string tag, input logic [7:0] s[$], input int unsigned budget);
        int unsigned n;
        logic [37:0] halt_io;
        load_mem(s);
        build_model(s);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check({tag, " rst csb"}, flash_csb, 1'b1);
        check({tag, " rst sclk"}, flash_clk, 1'b0);
        check({tag, " rst mosi"}, flash_io0, 1'b0);
        check({tag, " rst mprj"}, mprj_io, 38'h48);
        check({tag, " rst gpio"}, gpio, 1'b0);
        gap_q.delete();
        chk_seen.delete();
        uart_seen.delete();
        reset = 1'b0;
        @(negedge clock);
        check({tag, " csb low after release"}, flash_csb, 1'b0);
        n = 1;
        while (gpio !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        check({tag, " finished in budget"}, (n < budget), 1'b1);
        repeat (4) @(negedge clock);
        check({tag, " cmd"}, cmd_cap, 32'h03000000);
        check({tag, " gap count"}, gap_q.size(), exp_gap.size());
        for (int i = 0; i < exp_gap.size() && i < gap_q.size(); i++) begin
            check($sformatf("%s gap[%0d]", tag, i), gap_q[i], exp_gap[i]);
            if (gap_q[i] != exp_gap[i]) break;
        end
        check({tag, " chk count"}, chk_seen.size(), exp_chk.size());
        for (int i = 0; i < exp_chk.size() && i < chk_seen.size(); i++)
            check($sformatf("%s chk[%0d]", tag, i), chk_seen[i], exp_chk[i]);
        check({tag, " uart count"}, uart_seen.size(), exp_uart.size());
        for (int i = 0; i < exp_uart.size() && i < uart_seen.size(); i++)
            check($sformatf("%s uart[%0d]", tag, i), uart_seen[i], exp_uart[i]);
        halt_io = {6'b0, exp_final, 9'b0, 1'b1, 2'b0, 1'b1, 3'b0};
        check({tag, " halt csb"}, flash_csb, 1'b1);
        check({tag, " halt mprj"}, mprj_io, halt_io);
        repeat (20) @(negedge clock);
        check({tag, " halt hold"}, {gpio, flash_csb, flash_clk, mprj_io}, {3'b110, halt_io});
    endtask

    typedef struct {
        logic [23:0] rec [8];
        int          nrec;
        logic [15:0] final_chk;
        int          n_chk;
        int          n_uart;
    } vec_t;
    vec_t tbl [5];

    initial begin
        logic [7:0]  s[$];
        logic [15:0] d;
        logic [7:0]  op;
        int unsigned n;

        tbl[0].rec = '{24'h01AB40, 24'h01003E, 24'h010044, 24'h01004A,
                       24'h010050, 24'h01AB51, 24'h000000, 24'h000000};
        tbl[0].nrec = 7; tbl[0].final_chk = 16'hAB51; tbl[0].n_chk = 6; tbl[0].n_uart = 0;
        tbl[1].rec = '{24'h020041, 24'h000000, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
        tbl[1].nrec = 2; tbl[1].final_chk = 16'h0000; tbl[1].n_chk = 0; tbl[1].n_uart = 1;
        tbl[2].rec = '{24'h030009, 24'h011234, 24'h000000, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
        tbl[2].nrec = 3; tbl[2].final_chk = 16'h1234; tbl[2].n_chk = 1; tbl[2].n_uart = 0;
        tbl[3].rec = '{24'h01BEEF, 24'h030000, 24'h02005A, 24'h01BEEF,
                       24'h01C0DE, 24'hFF0000, 24'h0, 24'h0};
        tbl[3].nrec = 6; tbl[3].final_chk = 16'hC0DE; tbl[3].n_chk = 2; tbl[3].n_uart = 1;
        tbl[4].rec = '{24'h017777, 24'h7E1234, 24'h019999, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
        tbl[4].nrec = 3; tbl[4].final_chk = 16'h7777; tbl[4].n_chk = 1; tbl[4].n_uart = 0;

        for (int t = 0; t < 5; t++) begin
            s.delete();
            for (int r = 0; r < tbl[t].nrec; r++) begin
                s.push_back(tbl[t].rec[r][23:16]);
                s.push_back(tbl[t].rec[r][15:8]);
                s.push_back(tbl[t].rec[r][7:0]);
            end
            run_script($sformatf("tbl%0d", t), s, 20000);
            check($sformatf("tbl%0d final chk", t), mprj_io[31:16], tbl[t].final_chk);
            check($sformatf("tbl%0d n chk", t), chk_seen.size(), tbl[t].n_chk);
            check($sformatf("tbl%0d n uart", t), uart_seen.size(), tbl[t].n_uart);
            if (t == 2) begin
                // 10 idle clocks for D=9 on top of the 2-cycle record turnaround
                check("delay gap", (gap_q.size() > 56) ? gap_q[56] : 0, 12);
            end
        end

        for (int t = 0; t < 6; t++) begin
            s.delete();
            for (int r = 0; r < $urandom_range(2, 6); r++) begin
                case ($urandom_range(0, 2))
                    0:       begin op = 8'h01; d = 16'($urandom); end
                    1:       begin op = 8'h02; d = 16'($urandom); end
                    default: begin op = 8'h03; d = 16'($urandom_range(0, 20)); end
                endcase
                s.push_back(op); s.push_back(d[15:8]); s.push_back(d[7:0]);
            end
            case ($urandom_range(0, 2))
                0:       op = 8'h00;
                1:       op = 8'hFF;
                default: op = 8'($urandom_range(4, 254));
            endcase
            d = 16'($urandom);
            s.push_back(op); s.push_back(d[15:8]); s.push_back(d[7:0]);
            run_script($sformatf("rnd%0d", t), s, 20000);
        end

        // Reset in the middle of a UART frame, then a full rerun from the command.
        s.delete();
        s.push_back(8'h02); s.push_back(8'h00); s.push_back(8'h41);
        s.push_back(8'h00); s.push_back(8'h00); s.push_back(8'h00);
        load_mem(s);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        n = 0;
        while (mprj_io[6] !== 1'b0 && n < 500) begin
            @(negedge clock);
            n++;
        end
        check("mid-uart start seen", (n < 500), 1'b1);
        repeat (6) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("mid-uart rst tx/csb/gpio/sclk", {mprj_io[6], flash_csb, gpio, flash_clk}, 4'b1100);
        run_script("after mid-uart rst", s, 20000);

`ifdef CARAVEL_LITE_WATCHDOG_EN
        s.delete();
        s.push_back(8'h03); s.push_back(8'hFF); s.push_back(8'hFF);
        load_mem(s);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        n = 0;
        while (gpio !== 1'b1 && n < 1100) begin
            @(negedge clock);
            n++;
        end
        check("wdog latency", (n >= 990 && n <= 1001), 1'b1);
        check("wdog chk", mprj_io[31:16], 16'hDEAD);
        check("wdog csb", flash_csb, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
